// File: rtl/sram_arbiter.sv
// Round-robin two-port sequencer for the external 1Mx16 SRAM.
// Strobes, data-bus enable and done pulses are registered from the current state, so they lag the FSM by one cycle.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [15:0]       p0_wdata,
  output logic [15:0]       p0_rdata,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [15:0]       p1_wdata,
  output logic [15:0]       p1_rdata,
  output logic              p1_done,
  output logic              busy,
  output logic [19:0]       ADDR,
  input  logic [15:0]       Data_in,
  output logic [15:0]       Data_out,
  output logic              Data_oe,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB
);

  // state  | meaning
  // IDLE   | no transaction; grant on any request
  // SETUP  | address/CE settle, write data driven, WE still high
  // ACCESS | WE low (write) or OE sampling window (read), WAIT_CYCLES long
  // DONE   | strobes released, write data held, done pulse to grantee
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              gnt_id, last_grant, cur_we;
  logic              any_req, pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;
  logic              ce_d, oe_d, we_d, doe_d, done0_d, done1_d;

  assign any_req = p0_req | p1_req;
  assign busy    = (state != IDLE);

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    if (p0_req && p1_req) pick = ~last_grant;
    else if (p0_req)      pick = 1'b0;
    else                  pick = 1'b1;
    sel_we    = pick ? p1_we    : p0_we;
    sel_addr  = pick ? p1_addr  : p0_addr;
    sel_wdata = pick ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    doe_d   = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state)
      SETUP: begin
        ce_d = 1'b0;
        if (cur_we) doe_d = 1'b1;
        else        oe_d  = 1'b0;
      end
      ACCESS: begin
        ce_d = 1'b0;
        if (cur_we) begin
          we_d  = 1'b0;
          doe_d = 1'b1;
        end else begin
          oe_d = 1'b0;
        end
      end
      DONE: begin
        doe_d   = cur_we;
        done0_d = ~gnt_id;
        done1_d = gnt_id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt        <= '0;
      gnt_id     <= 1'b0;
      last_grant <= 1'b1;
      cur_we     <= 1'b0;
      ADDR       <= '0;
      Data_out   <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt_id     <= pick;
          last_grant <= pick;
          cur_we     <= sel_we;
          ADDR       <= 20'(sel_addr);
          Data_out   <= sel_wdata;
        end
        SETUP: cnt <= CNT_W'(WAIT_CYCLES - 1);
        ACCESS: begin
          if (cnt == '0) begin
            if (!cur_we) begin
              if (gnt_id) p1_rdata <= Data_in;
              else        p0_rdata <= Data_in;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      CE      <= 1'b1;
      OE      <= 1'b1;
      WE      <= 1'b1;
      UB      <= 1'b1;
      LB      <= 1'b1;
      Data_oe <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
    end else begin
      CE      <= ce_d;
      OE      <= oe_d;
      WE      <= we_d;
      UB      <= ce_d;
      LB      <= ce_d;
      Data_oe <= doe_d;
      p0_done <= done0_d;
      p1_done <= done1_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM model and an expected-completion queue.
module tb_sram_arbiter;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [15:0] p0_rdata, p1_rdata;
  logic        p0_done, p1_done, busy;
  logic [19:0] ADDR;
  logic [15:0] Data_in, Data_out;
  logic        Data_oe, CE, OE, WE, UB, LB;

  sram_arbiter #(.WAIT_CYCLES(2), .ADDR_W(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_done(p1_done),
    .busy(busy), .ADDR(ADDR), .Data_in(Data_in), .Data_out(Data_out),
    .Data_oe(Data_oe), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB)
  );

  always #5 Clk = ~Clk;

  logic [15:0] mem [256];
  always @(posedge Clk) if (!CE && !WE) mem[ADDR[7:0]] <= Data_out;
  assign Data_in = (!CE && !OE) ? mem[ADDR[7:0]] : 16'hDEAD;

  int ce_n = 0, we_n = 0, oe_n = 0, doe_n = 0, doe_rd_n = 0, be_viol = 0, d0_n = 0, d1_n = 0;
  always @(negedge Clk) begin
    if (!CE) ce_n++;
    if (!WE) we_n++;
    if (!OE) oe_n++;
    if (Data_oe) doe_n++;
    if (Data_oe && !OE) doe_rd_n++;
    if (UB !== CE || LB !== CE) be_viol++;
    if (p0_done) d0_n++;
    if (p1_done) d1_n++;
  end

  typedef struct {bit port; bit rd; logic [15:0] data;} exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int last_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit port, input bit rd, input logic [15:0] data);
    exp_t e;
    e.port = port; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  task automatic handle(input bit port);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_done", {31'd0, port}, 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("sb_port_order", {31'd0, port}, {31'd0, e.port});
      if (e.rd) chk("sb_rdata", port ? p1_rdata : p0_rdata, e.data);
    end
  endtask

  task automatic run(input bit go0, input bit go1, input int budget);
    int pend = int'(go0) + int'(go1);
    int n = 0;
    p0_req = go0;
    p1_req = go1;
    while (pend > 0 && n < budget) begin
      @(negedge Clk); #1; n++;
      if (p0_done) begin handle(1'b0); p0_req = 1'b0; pend--; end
      if (p1_done) begin handle(1'b1); p1_req = 1'b0; pend--; end
    end
    last_lat = n;
    chk("run_timeout_pending", pend, 0);
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic set_p0(input bit we, input logic [15:0] a, input logic [15:0] d);
    p0_we = we; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set_p1(input bit we, input logic [15:0] a, input logic [15:0] d);
    p1_we = we; p1_addr = a; p1_wdata = d;
  endtask

  task automatic pulse_reset();
    @(negedge Clk); #1;
    Reset = 1'b1;
    @(negedge Clk); #1;
    Reset = 1'b0;
  endtask

  initial begin
    int ce0, we0, oe0, doe0, doerd0, d00, d10, n;
    bit seen;
    Reset = 1'b1;
    p0_req = 0; p1_req = 0;
    set_p0(0, 16'h0, 16'h0);
    set_p1(0, 16'h0, 16'h0);
    repeat (3) @(negedge Clk);
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clk);

    // 1: reset pulse while idle
    #1 Reset = 1'b1;
    #1;
    chk("rst_ce", CE, 1); chk("rst_oe", OE, 1); chk("rst_we", WE, 1);
    chk("rst_ub", UB, 1); chk("rst_lb", LB, 1); chk("rst_doe", Data_oe, 0);
    chk("rst_addr", ADDR, 0); chk("rst_busy", busy, 0);
    chk("rst_p0_done", p0_done, 0); chk("rst_p1_done", p1_done, 0);
    chk("rst_p0_rdata", p0_rdata, 0); chk("rst_p1_rdata", p1_rdata, 0);
    @(negedge Clk); #1 Reset = 1'b0;
    @(negedge Clk); #1;

    // 2: p0 write 0x1234 @ 0x0042
    ce0 = ce_n; we0 = we_n; oe0 = oe_n; doe0 = doe_n; d00 = d0_n;
    set_p0(1, 16'h0042, 16'h1234);
    push(0, 0, 16'h0);
    run(1, 0, 20);
    chk("wr_latency", last_lat, 5);
    chk("wr_addr", ADDR, 20'h00042);
    chk("wr_data_out", Data_out, 16'h1234);
    repeat (3) @(negedge Clk); #1;
    chk("wr_ce_cycles", ce_n - ce0, 3);
    chk("wr_we_cycles", we_n - we0, 2);
    chk("wr_oe_cycles", oe_n - oe0, 0);
    chk("wr_doe_cycles", doe_n - doe0, 4);
    chk("wr_done_count", d0_n - d00, 1);
    chk("wr_busy_after", busy, 0);

    // 3: p1 read back @ 0x0042
    ce0 = ce_n; we0 = we_n; oe0 = oe_n; doe0 = doe_n; d10 = d1_n;
    set_p1(0, 16'h0042, 16'h0);
    push(1, 1, 16'h1234);
    run(0, 1, 20);
    chk("rd_latency", last_lat, 5);
    repeat (3) @(negedge Clk); #1;
    chk("rd_oe_cycles", oe_n - oe0, 3);
    chk("rd_we_cycles", we_n - we0, 0);
    chk("rd_doe_cycles", doe_n - doe0, 0);
    chk("rd_done_count", d1_n - d10, 1);
    chk("rd_p1_rdata", p1_rdata, 16'h1234);
    chk("rd_p0_rdata_kept", p0_rdata, 16'h0);

    // 4: contention from reset, then round robin
    pulse_reset();
    set_p0(1, 16'h0010, 16'h1111);
    set_p1(1, 16'h0020, 16'h2222);
    push(0, 0, 16'h0);
    push(1, 0, 16'h0);
    run(1, 1, 40);
    set_p0(0, 16'h0020, 16'h0);
    set_p1(0, 16'h0010, 16'h0);
    push(0, 1, 16'h2222);
    push(1, 1, 16'h1111);
    run(1, 1, 40);
    chk("rr_sb_empty", sb.size(), 0);

    // 5: reset during ACCESS of a write
    d00 = d0_n; d10 = d1_n;
    set_p0(1, 16'h0100, 16'hBEEF);
    push(0, 0, 16'h0);
    p0_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clk); #1;
      if (WE === 1'b0) seen = 1;
    end
    chk("mid_we_seen", seen, 1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_we", WE, 1); chk("mid_rst_ce", CE, 1);
    chk("mid_rst_doe", Data_oe, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_p1_rdata", p1_rdata, 0);
    p0_req = 1'b0;
    sb.delete();
    @(negedge Clk); #1 Reset = 1'b0;
    repeat (8) @(negedge Clk); #1;
    chk("mid_no_done0", d0_n - d00, 0);
    chk("mid_no_done1", d1_n - d10, 0);
    set_p1(0, 16'h0042, 16'h0);
    push(1, 1, 16'h1234);
    run(0, 1, 20);
    chk("mid_p1_rdata", p1_rdata, 16'h1234);

    // 6: p0 read with request dropped during SETUP
    @(negedge Clk); #1;
    ce0 = ce_n; oe0 = oe_n; d00 = d0_n;
    set_p0(0, 16'h0042, 16'h0);
    push(0, 1, 16'h1234);
    p0_req = 1'b1;
    @(negedge Clk); #1;
    p0_req = 1'b0;
    chk("drop_busy_setup", busy, 1);
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge Clk); #1; n++;
      if (p0_done) begin handle(1'b0); seen = 1; end
    end
    chk("drop_done_seen", seen, 1);
    repeat (6) @(negedge Clk); #1;
    chk("drop_ce_cycles", ce_n - ce0, 3);
    chk("drop_oe_cycles", oe_n - oe0, 3);
    chk("drop_done_count", d0_n - d00, 1);
    chk("drop_busy_idle", busy, 0);
    chk("drop_sb_empty", sb.size(), 0);

    chk("byte_enable_track", be_viol, 0);
    chk("doe_during_read", doe_n >= 0 ? doerd_total() : 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic int doerd_total();
    return doe_rd_n;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
